// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: default widths, reset PC and memory depth.
package instr_fetch_pkg;

    localparam int            ADDR_W_DEF   = 12;
    localparam int            DATA_W_DEF   = 12;
    localparam logic [11:0]   RESET_PC_DEF = 12'h000;
    localparam int            IMEM_DEPTH   = 4096;
    localparam int            BUF_DEPTH    = 2;
    localparam int            CNT_W        = 2;

    // Slots still free once the buffered words and the outstanding read are counted.
    function automatic logic has_credit(input logic [CNT_W-1:0] count, input logic inflight);
        return ({1'b0, count} + {2'b00, inflight}) < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} skid FIFO between the instruction memory and decode.
// Entry 0 is always the head; flush empties it in one cycle.
module fetch_buf
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [ADDR_W-1:0] pc_q    [BUF_DEPTH];
    logic [DATA_W-1:0] instr_q [BUF_DEPTH];
    logic [CNT_W-1:0]  count_q;

    // Storage and occupancy; push into the slot after the last valid entry,
    // pop shifts entry 1 down so the head stays in slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc_q[0]    <= push_pc_i;
                        instr_q[0] <= push_instr_i;
                        count_q    <= count_q + 2'd1;
                    end else if (count_q == 2'd1) begin
                        pc_q[1]    <= push_pc_i;
                        instr_q[1] <= push_instr_i;
                        count_q    <= count_q + 2'd1;
                    end
                end
                2'b01: begin
                    pc_q[0]    <= pc_q[1];
                    instr_q[0] <= instr_q[1];
                    count_q    <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands right behind the survivor.
                    if (count_q == 2'd1) begin
                        pc_q[0]    <= push_pc_i;
                        instr_q[0] <= push_instr_i;
                    end else if (count_q == 2'd2) begin
                        pc_q[0]    <= pc_q[1];
                        instr_q[0] <= instr_q[1];
                        pc_q[1]    <= push_pc_i;
                        instr_q[1] <= push_instr_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = (count_q == 2'd0) ? '0 : pc_q[0];
    assign head_instr_o = (count_q == 2'd0) ? '0 : instr_q[0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one read in flight to the synchronous
// instruction memory and hands {pc, instr} to decode through a 2-entry buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count;
    logic              pop, push, issue;

    // A redirect hides the wrong-path head and claims the memory port.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !redirect_valid;
    assign issue     = redirect_valid || pop || has_credit(count, inflight_q);
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;

    // Next PC / in-flight tracking; a read is issued only when its response has a slot.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = imem_addr;
            fetch_pc_d    = imem_addr + ADDR_W'(1);
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (imem_data),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .count_o      (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model mem[i] = i ^ 12'hA5A, expected
// PCs queued by the stimulus and checked as decode accepts them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] imem_addr;
    logic [11:0] imem_data = '0;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pc;
    logic [11:0] out_instr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mem_word(input logic [11:0] a);
        return a ^ 12'hA5A;
    endfunction

    // Synchronous-read instruction memory, one cycle latency.
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted instruction must be the next expected PC.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("credit", 32'(({1'b0, dut.u_buf.count_o} + {2'b0, dut.inflight_q}) <= 3'd2), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pc", 32'(out_pc), 32'hFFFF_FFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", 32'(out_pc), 32'(e));
                    check("sb_instr", 32'(out_instr), 32'(mem_word(e)));
                end
            end
        end
    end

    task automatic push_seq(input logic [11:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 12'(i));
    endtask

    // Wait for the scoreboard to empty; returns at posedge+1.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    // Release reset between edges and check first-fetch timing.
    task automatic startup();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("start_e2_valid", 32'(out_valid), 32'd1);
        check("start_e2_pc", 32'(out_pc), 32'h000);
    endtask

    // One-cycle redirect pulse; target must be presented two edges later.
    task automatic redirect(input logic [11:0] tgt, input int n);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        #1;
        check("redir_hide", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'(tgt));
        push_seq(tgt, n);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("redir_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("redir_e2_valid", 32'(out_valid), 32'd1);
        check("redir_e2_pc", 32'(out_pc), 32'(tgt));
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Startup stream 0..4, then redirect while pc 5 is at the head.
        push_seq(12'h000, 5);
        startup();
        drain();
        check("pre_redir_pc", 32'(out_pc), 32'h005);
        redirect(12'h100, 8);
        drain();

        // Stall with 0x108 at the head: buffer fills, issue halts.
        out_ready = 1'b0;
        #1;
        check("stall_pc0", 32'(out_pc), 32'h108);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", 32'(out_pc), 32'h108);
            check("stall_addr", 32'(imem_addr), 32'h10A);
        end
        push_seq(12'h108, 5);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("resume_nogap", 32'(out_valid), 32'd1);
        end
        drain();

        // Wrap around the top of the address space.
        redirect(12'hFFE, 4);
        drain();

        // Redirect while the buffer is full and decode is stalled.
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_pc", 32'(out_pc), 32'h002);
        redirect(12'h040, 4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("held_valid", 32'(out_valid), 32'd1);
            check("held_pc", 32'(out_pc), 32'h040);
            check("held_instr", 32'(out_instr), 32'(mem_word(12'h040)));
        end
        out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", 32'(out_pc), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_seq(12'h000, 3);
        startup();
        drain();
        out_ready = 1'b0;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
